udp_payload_streamer: RTL and testbench
=======================================

Name: udp_payload_streamer

Overview:
Downstream stage of the UDP parser. When the parser pulses start_read, this block reads the payload words the parser wrote into the payload RAM, from FIRST_ADDR through last_addr inclusive. It serialises each 32-bit word into bytes, MSB first, on a valid/ready byte stream for the transmit/output side. A one-word prefetch buffer keeps the stream at one byte per clock while the consumer accepts continuously.

Parameters:
FIRST_ADDR, 0, RAM address of first payload word
ADDR_W, 10, RAM address width (matches parser rd/wr address width)
DATA_W, 32, RAM word width; fixed at 4 bytes per word

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_read  in  1  one-cycle pulse from parser: payload complete
last_addr  in  ADDR_W  last written payload word address, valid with start_read
rd_addr  out  ADDR_W  payload RAM read address
rd_data  in  DATA_W  payload RAM read data, 1-cycle latency after rd_addr
m_data  out  8  output byte
m_valid  out  1  m_data valid
m_ready  in  1  consumer accepts byte
m_last  out  1  high with final byte of payload
busy  out  1  high from accepted start_read until done
done  out  1  one-cycle pulse after final byte accepted (or empty payload)
err_overrun  out  1  one-cycle pulse: start_read arrived while busy

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. On rst_n low, all outputs go 0 immediately: rd_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, err_overrun=0. State returns to IDLE and buffers are invalidated. Reset mid-transfer drops the payload with no done pulse.
- Transfer rule: a byte transfers on a rising edge with m_valid && m_ready. While m_valid && !m_ready, m_data and m_last hold stable. m_valid never drops without a transfer.
- Byte order: each word emits [31:24], [23:16], [15:8], [7:0].
- Word count: N = last_addr - FIRST_ADDR + 1, computed ADDR_W+1 wide. last_addr < FIRST_ADDR means an empty payload.
- State machine (states in shared package):
  - IDLE: on start_read, latch last_addr into end_addr, set busy, drive rd_addr=FIRST_ADDR, go to FETCH. If the payload is empty, go to FINISH instead and do not assert busy.
  - FETCH: wait one cycle for RAM latency. Load rd_data into the shift register (bytes_left=4). If more words remain, increment rd_addr. Go to STREAM.
  - STREAM:
    - Present shift-register byte, m_valid=1; on each transfer shift left 8 and decrement bytes_left.
    - Prefetch: one cycle after rd_addr advances, capture rd_data into the prefetch register (pf_valid=1). Do not issue another read while pf_valid=1.
    - When the last byte of a word transfers and pf_valid=1, load the prefetch into the shift register in the same cycle, so there is no bubble. Clear pf_valid. Advance rd_addr if rd_addr != end_addr.
    - m_last=1 while presenting byte 3 of the word at end_addr.
    - After the m_last transfer, go to FINISH.
  - FINISH: pulse done for 1 cycle, clear busy, m_valid=0, go to IDLE.
- Latency: start_read sampled at edge E gives first m_valid after edge E+2. Throughput is 1 byte/clk with m_ready held high, for 4N bytes total.
- Overrun: start_read in any state other than IDLE pulses err_overrun for 1 cycle. The current transfer continues unchanged and the new last_addr is ignored.
- start_read in the same cycle as the done pulse (FINISH) counts as an overrun and is not accepted.
- Address wrap: rd_addr never increments past end_addr. last_addr = 2^ADDR_W-1 is legal and has no wrap.
- Single-word payload (last_addr=FIRST_ADDR): no prefetch read is issued. m_last is asserted on the 4th byte.

Decomposition:
- Shared package (udp_pkg): streamer state enum {IDLE, FETCH, STREAM, FINISH}, BYTES_PER_WORD=4, ADDR_W default.
- One sub-module, word_serializer: shift register, bytes_left counter, prefetch slot, and byte handshake. The top holds the FSM and address/count logic.

Test Plan:
- Basic: RAM[0..2]=0x11223344, 0x55667788, 0x99AABBCC; start_read with last_addr=2; m_ready=1. Expect bytes 11,22,…,CC on 12 consecutive cycles starting edge E+2; m_last on CC; done 1 cycle later; busy deasserted.
- Backpressure: same data, m_ready toggled 1,0,0,1 repeating. Expect identical byte sequence; m_data stable during stalls; no dropped or duplicated byte; rd_addr never exceeds 2.
- Single word and empty:
  - last_addr=0 with FIRST_ADDR=0: expect 4 bytes, m_last on the 4th.
  - FIRST_ADDR=1 with last_addr=0: expect no m_valid and a done pulse 1 cycle after start_read.
- Overrun: start_read again mid-stream with last_addr=5. Expect an err_overrun pulse; stream still ends after 12 bytes with done.
- Async reset: assert rst_n=0 mid-word, between clock edges. Expect all outputs 0 before the next edge. After release, a new start_read streams correctly from FIRST_ADDR.
- Max address: FIRST_ADDR=1022, last_addr=1023. Expect 8 bytes; rd_addr sequence 1022, 1023; no wrap to 0.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP payload streamer: state encoding and word geometry.
package udp_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } stream_state_e;

endpackage

// File: rtl/word_serializer.sv
// Turns 32-bit payload words into an MSB-first byte stream with a one-word prefetch slot,
// so the next word is already on hand when the current one runs out.
module word_serializer
    import udp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              pf_capture,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_is_last,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              pf_valid,
    output logic              word_done
);

    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] bytes_left_q, bytes_left_d;
    logic                  cur_last_q, cur_last_d;
    logic [DATA_W-1:0]     pf_data_q, pf_data_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  pf_last_q, pf_last_d;
    logic                  xfer;

    assign m_valid   = (bytes_left_q != '0);
    assign xfer      = m_valid && m_ready;
    assign word_done = xfer && (bytes_left_q == BYTE_CNT_W'(1));
    assign m_data    = shift_q[DATA_W-1 -: 8];
    assign m_last    = cur_last_q && (bytes_left_q == BYTE_CNT_W'(1));
    assign pf_valid  = pf_valid_q;

    // Next-state for the shift register, byte counter and prefetch slot.
    always_comb begin
        shift_d      = shift_q;
        bytes_left_d = bytes_left_q;
        cur_last_d   = cur_last_q;
        pf_data_d    = pf_data_q;
        pf_valid_d   = pf_valid_q;
        pf_last_d    = pf_last_q;

        if (load_en) begin
            shift_d      = word_in;
            bytes_left_d = BYTE_CNT_W'(BYTES_PER_WORD);
            cur_last_d   = word_is_last;
        end else if (xfer) begin
            if (word_done && pf_valid_q) begin
                // Swap in the prefetched word on the same edge so the stream never bubbles.
                shift_d      = pf_data_q;
                bytes_left_d = BYTE_CNT_W'(BYTES_PER_WORD);
                cur_last_d   = pf_last_q;
                pf_valid_d   = 1'b0;
            end else begin
                shift_d      = shift_q << 8;
                bytes_left_d = bytes_left_q - BYTE_CNT_W'(1);
            end
        end

        if (pf_capture) begin
            pf_data_d  = word_in;
            pf_valid_d = 1'b1;
            pf_last_d  = word_is_last;
        end
    end

    // Register the serializer state; reset empties both the shift register and the prefetch slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            bytes_left_q <= '0;
            cur_last_q   <= 1'b0;
            pf_data_q    <= '0;
            pf_valid_q   <= 1'b0;
            pf_last_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            cur_last_q   <= cur_last_d;
            pf_data_q    <= pf_data_d;
            pf_valid_q   <= pf_valid_d;
            pf_last_q    <= pf_last_d;
        end
    end

endmodule

// File: rtl/udp_payload_streamer.sv
// Reads a completed UDP payload out of the payload RAM and streams it as bytes.
// Holds the control FSM, the RAM address walk and read-latency tracking; byte handling
// lives in word_serializer.
module udp_payload_streamer
    import udp_pkg::*;
#(
    parameter int FIRST_ADDR = 0,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err_overrun
);

    localparam logic [ADDR_W-1:0] FIRST     = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W:0]   FIRST_EXT = (ADDR_W+1)'(FIRST_ADDR);

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic              rd_req_q, rd_req_d;
    logic              rd_vld_q, rd_vld_d;
    logic              err_overrun_q, err_overrun_d;

    logic [ADDR_W:0]   last_plus1;
    logic              empty_req;
    logic              at_end;
    logic              ser_load;
    logic              ser_capture;
    logic              ser_word_done;
    logic              ser_pf_valid;
    logic              ser_m_last;

    // Word count is last_addr + 1 - FIRST_ADDR, one bit wider than an address so the top
    // address is legal; the payload is empty when last_addr + 1 does not exceed FIRST_ADDR.
    assign last_plus1 = {1'b0, last_addr} + (ADDR_W+1)'(1);
    assign empty_req  = (last_plus1 <= FIRST_EXT);
    assign at_end     = (rd_addr_q == end_addr_q);

    assign rd_addr     = rd_addr_q;
    assign busy        = (state_q == FETCH) || (state_q == STREAM);
    assign done        = (state_q == FINISH);
    assign err_overrun = err_overrun_q;
    assign m_last      = ser_m_last;

    // Next-state, address walk and serializer control.
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        end_addr_d    = end_addr_q;
        rd_req_d      = 1'b0;
        rd_vld_d      = rd_req_q;
        ser_load      = 1'b0;
        ser_capture   = 1'b0;
        err_overrun_d = start_read && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_read) begin
                    end_addr_d = last_addr;
                    if (empty_req) begin
                        state_d = FINISH;
                    end else begin
                        rd_addr_d = FIRST;
                        rd_req_d  = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end

            FETCH: begin
                if (rd_vld_q) begin
                    ser_load = 1'b1;
                    state_d  = STREAM;
                    if (!at_end) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        rd_req_d  = 1'b1;
                    end
                end
            end

            STREAM: begin
                ser_capture = rd_vld_q;
                if (ser_word_done) begin
                    if (ser_m_last) begin
                        state_d = FINISH;
                    end else if (ser_pf_valid && !at_end) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        rd_req_d  = 1'b1;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            end_addr_q    <= '0;
            rd_req_q      <= 1'b0;
            rd_vld_q      <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            end_addr_q    <= end_addr_d;
            rd_req_q      <= rd_req_d;
            rd_vld_q      <= rd_vld_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    word_serializer #(
        .DATA_W(DATA_W)
    ) u_word_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (ser_load),
        .pf_capture  (ser_capture),
        .word_in     (rd_data),
        .word_is_last(at_end),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (ser_m_last),
        .pf_valid    (ser_pf_valid),
        .word_done   (ser_word_done)
    );

endmodule

// File: tb/tb_udp_payload_streamer.sv
// Bench for udp_payload_streamer: three instances with different FIRST_ADDR values,
// each fed by its own registered RAM, checked against a queue-based payload model.
module tb_udp_payload_streamer;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int NUM_DUT   = 3;
    localparam int BUF_DEPTH = 64;
    localparam int RAM_WORDS = 1024;

    logic clk = 1'b0;
    logic rst_n;

    logic              start_read  [NUM_DUT];
    logic [ADDR_W-1:0] last_addr   [NUM_DUT];
    logic [ADDR_W-1:0] rd_addr     [NUM_DUT];
    logic [DATA_W-1:0] rd_data     [NUM_DUT];
    logic [7:0]        m_data      [NUM_DUT];
    logic              m_valid     [NUM_DUT];
    logic              m_ready     [NUM_DUT];
    logic              m_last      [NUM_DUT];
    logic              busy        [NUM_DUT];
    logic              done        [NUM_DUT];
    logic              err_overrun [NUM_DUT];

    logic [DATA_W-1:0] ramMem [NUM_DUT][RAM_WORDS];

    int checks = 0;
    int errors = 0;

    // Payload model: the bytes a transfer must deliver plus its timing milestones.
    logic [7:0]        mBuf [NUM_DUT][BUF_DEPTH];
    int                mHead [NUM_DUT];
    int                mTail [NUM_DUT];
    int                mAge [NUM_DUT];
    bit                mActive [NUM_DUT];
    bit                mDone [NUM_DUT];
    bit                mOvr [NUM_DUT];
    logic [ADDR_W-1:0] mEnd [NUM_DUT];

    // Observation of what the DUTs actually delivered.
    logic [7:0] obs [NUM_DUT][BUF_DEPTH];
    int         obsCnt [NUM_DUT];
    int         ovrCnt;
    int         rdMin;
    int         rdMax;

    always #5 clk = ~clk;

    function automatic int firstOf(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 1022;
        endcase
    endfunction

    for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
        udp_payload_streamer #(
            .FIRST_ADDR(firstOf(g)),
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_read (start_read[g]),
            .last_addr  (last_addr[g]),
            .rd_addr    (rd_addr[g]),
            .rd_data    (rd_data[g]),
            .m_data     (m_data[g]),
            .m_valid    (m_valid[g]),
            .m_ready    (m_ready[g]),
            .m_last     (m_last[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .err_overrun(err_overrun[g])
        );

        // Registered payload RAM: data for an address appears one clock after it is presented.
        always @(posedge clk) rd_data[g] <= ramMem[g][rd_addr[g]];
    end

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endtask

    function automatic bit expValid(input int i);
        return mActive[i] && (mAge[i] >= 2) && (mHead[i] < mTail[i]);
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NUM_DUT; i++) begin
            mHead[i]   = 0;
            mTail[i]   = 0;
            mAge[i]    = 0;
            mActive[i] = 1'b0;
            mDone[i]   = 1'b0;
            mOvr[i]    = 1'b0;
            mEnd[i]    = '0;
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled on that edge.
    task automatic modelStep();
        for (int i = 0; i < NUM_DUT; i++) begin
            bit                wasBusy;
            bit                xfer;
            bit                nd;
            bit                no;
            logic [DATA_W-1:0] word;
            wasBusy = mActive[i] || mDone[i];
            xfer    = expValid(i) && m_ready[i];
            nd      = 1'b0;
            no      = 1'b0;
            if (mActive[i]) begin
                if (xfer) begin
                    mHead[i]++;
                    if (mHead[i] == mTail[i]) begin
                        mActive[i] = 1'b0;
                        nd         = 1'b1;
                    end
                end
                mAge[i]++;
            end
            if (start_read[i]) begin
                if (wasBusy) begin
                    no = 1'b1;
                end else begin
                    mHead[i] = 0;
                    mTail[i] = 0;
                    mAge[i]  = 0;
                    mEnd[i]  = last_addr[i];
                    for (int a = firstOf(i); a <= int'(last_addr[i]); a++) begin
                        word = ramMem[i][a];
                        for (int b = 3; b >= 0; b--) begin
                            if (mTail[i] < BUF_DEPTH) begin
                                mBuf[i][mTail[i]] = word[8*b +: 8];
                                mTail[i]++;
                            end
                        end
                    end
                    if (mTail[i] == 0) nd = 1'b1;
                    else mActive[i] = 1'b1;
                end
            end
            mDone[i] = nd;
            mOvr[i]  = no;
        end
    endtask

    // Model update on every clock edge, cleared immediately by reset.
    initial begin
        modelClear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) modelClear();
            else modelStep();
        end
    end

    // Compare every DUT against the model each cycle, and record delivered bytes.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_DUT; i++) begin
                bit ev;
                ev = expValid(i);
                checkOutput("m_valid", i, 32'(m_valid[i]), 32'(ev));
                checkOutput("busy", i, 32'(busy[i]), 32'(mActive[i]));
                checkOutput("done", i, 32'(done[i]), 32'(mDone[i]));
                checkOutput("err_overrun", i, 32'(err_overrun[i]), 32'(mOvr[i]));
                if (ev) begin
                    checkOutput("m_data", i, 32'(m_data[i]), 32'(mBuf[i][mHead[i]]));
                    checkOutput("m_last", i, 32'(m_last[i]), 32'(mHead[i] == mTail[i] - 1));
                end
                if (mActive[i]) begin
                    checkOutput("rd_addr_range", i,
                                32'((int'(rd_addr[i]) >= firstOf(i)) && (rd_addr[i] <= mEnd[i])), 32'd1);
                end
                if (m_valid[i] === 1'b1 && m_ready[i] === 1'b1 && obsCnt[i] < BUF_DEPTH) begin
                    obs[i][obsCnt[i]] = m_data[i];
                    obsCnt[i]++;
                end
            end
            if (err_overrun[0] === 1'b1) ovrCnt++;
            if (busy[2] === 1'b1) begin
                if (int'(rd_addr[2]) < rdMin) rdMin = int'(rd_addr[2]);
                if (int'(rd_addr[2]) > rdMax) rdMax = int'(rd_addr[2]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int i, input logic [ADDR_W-1:0] last);
        start_read[i] = 1'b1;
        last_addr[i]  = last;
        tick();
        start_read[i] = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, optionally toggling m_ready 1,0,0,1.
    task automatic waitDone(input int i, input bit bp, output int cycles);
        cycles = 0;
        while (done[i] !== 1'b1 && cycles < 300) begin
            if (bp) m_ready[i] = ((cycles % 4) == 0) || ((cycles % 4) == 3);
            tick();
            cycles++;
        end
        if (done[i] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout[%0d]: got no done expected done within 300 cycles", i);
        end
        m_ready[i] = 1'b1;
    endtask

    task automatic checkAllZero(input int i);
        checkOutput("rst_rd_addr", i, 32'(rd_addr[i]), 32'd0);
        checkOutput("rst_m_data", i, 32'(m_data[i]), 32'd0);
        checkOutput("rst_m_valid", i, 32'(m_valid[i]), 32'd0);
        checkOutput("rst_m_last", i, 32'(m_last[i]), 32'd0);
        checkOutput("rst_busy", i, 32'(busy[i]), 32'd0);
        checkOutput("rst_done", i, 32'(done[i]), 32'd0);
        checkOutput("rst_err_overrun", i, 32'(err_overrun[i]), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n  = 1'b0;
        ovrCnt = 0;
        rdMin  = RAM_WORDS;
        rdMax  = 0;
        for (int i = 0; i < NUM_DUT; i++) begin
            start_read[i] = 1'b0;
            last_addr[i]  = '0;
            m_ready[i]    = 1'b1;
            obsCnt[i]     = 0;
            for (int a = 0; a < RAM_WORDS; a++) ramMem[i][a] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            ramMem[i][0] = 32'h11223344;
            ramMem[i][1] = 32'h55667788;
            ramMem[i][2] = 32'h99AABBCC;
        end
        ramMem[2][0]    = 32'hFFFFFFFF;
        ramMem[2][1022] = 32'hDEADBEEF;
        ramMem[2][1023] = 32'h0BADF00D;

        repeat (3) tick();
        for (int i = 0; i < NUM_DUT; i++) checkAllZero(i);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] basic three-word payload");
        obsCnt[0] = 0;
        applyStimulus(0, 10'd2);
        checkOutput("model_tail", 0, 32'(mTail[0]), 32'd12);
        checkOutput("model_byte0", 0, 32'(mBuf[0][0]), 32'h11);
        checkOutput("model_byte11", 0, 32'(mBuf[0][11]), 32'hCC);
        waitDone(0, 1'b0, lat);
        checkOutput("basic_done_latency", 0, 32'(lat), 32'd14);
        checkOutput("basic_count", 0, 32'(obsCnt[0]), 32'd12);
        checkOutput("basic_first", 0, 32'(obs[0][0]), 32'h11);
        checkOutput("basic_fifth", 0, 32'(obs[0][4]), 32'h55);
        checkOutput("basic_last", 0, 32'(obs[0][11]), 32'hCC);
        repeat (2) tick();

        $display("[TB] backpressure");
        obsCnt[0] = 0;
        applyStimulus(0, 10'd2);
        waitDone(0, 1'b1, lat);
        checkOutput("bp_count", 0, 32'(obsCnt[0]), 32'd12);
        checkOutput("bp_eighth", 0, 32'(obs[0][7]), 32'h88);
        checkOutput("bp_last", 0, 32'(obs[0][11]), 32'hCC);
        repeat (2) tick();

        $display("[TB] single word");
        obsCnt[0] = 0;
        applyStimulus(0, 10'd0);
        waitDone(0, 1'b0, lat);
        checkOutput("single_done_latency", 0, 32'(lat), 32'd6);
        checkOutput("single_count", 0, 32'(obsCnt[0]), 32'd4);
        checkOutput("single_fourth", 0, 32'(obs[0][3]), 32'h44);
        repeat (2) tick();

        $display("[TB] empty payload");
        obsCnt[1] = 0;
        applyStimulus(1, 10'd0);
        waitDone(1, 1'b0, lat);
        checkOutput("empty_done_latency", 1, 32'(lat), 32'd0);
        repeat (2) tick();
        checkOutput("empty_count", 1, 32'(obsCnt[1]), 32'd0);

        $display("[TB] overrun mid-stream");
        obsCnt[0] = 0;
        ovrCnt    = 0;
        applyStimulus(0, 10'd2);
        repeat (4) tick();
        applyStimulus(0, 10'd5);
        waitDone(0, 1'b0, lat);
        checkOutput("ovr_pulses", 0, 32'(ovrCnt), 32'd1);
        checkOutput("ovr_count", 0, 32'(obsCnt[0]), 32'd12);
        checkOutput("ovr_last", 0, 32'(obs[0][11]), 32'hCC);
        repeat (2) tick();

        $display("[TB] asynchronous reset mid-word");
        applyStimulus(0, 10'd2);
        repeat (5) tick();
        #1 rst_n = 1'b0;
        #1 checkAllZero(0);
        tick();
        rst_n = 1'b1;
        tick();
        obsCnt[0] = 0;
        applyStimulus(0, 10'd2);
        waitDone(0, 1'b0, lat);
        checkOutput("post_reset_latency", 0, 32'(lat), 32'd14);
        checkOutput("post_reset_first", 0, 32'(obs[0][0]), 32'h11);
        checkOutput("post_reset_count", 0, 32'(obsCnt[0]), 32'd12);
        repeat (2) tick();

        $display("[TB] top of address space");
        obsCnt[2] = 0;
        applyStimulus(2, 10'd1023);
        waitDone(2, 1'b0, lat);
        checkOutput("max_done_latency", 2, 32'(lat), 32'd10);
        checkOutput("max_count", 2, 32'(obsCnt[2]), 32'd8);
        checkOutput("max_first", 2, 32'(obs[2][0]), 32'hDE);
        checkOutput("max_last", 2, 32'(obs[2][7]), 32'h0D);
        checkOutput("max_rd_min", 2, 32'(rdMin), 32'd1022);
        checkOutput("max_rd_max", 2, 32'(rdMax), 32'd1023);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
